// File: rtl/sum_sched_pkg.sv
// Shared types and constants for the bounded-sum run scheduler.
package sum_sched_pkg;

  localparam int DEF_W         = 11;
  localparam int DEF_TOTAL_MAX = 250;
  localparam int DEF_ACC_MAX   = 150;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [DEF_W-1:0] min_w(input logic [DEF_W-1:0] a,
                                             input logic [DEF_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/sum_datapath.sv
// Counting datapath: i steps up to Leff, sn follows i while i is within Aeff.
module sum_datapath
  import sum_sched_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_leff,
  input  logic [W-1:0] i_aeff,
  output logic [W-1:0] o_i,
  output logic [W-1:0] o_sn
);

  logic [W-1:0] r_i;
  logic [W-1:0] r_sn;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_i  <= W'(1);
      r_sn <= '0;
    end else if (i_load) begin
      r_i  <= W'(1);
      r_sn <= '0;
    end else if (i_en && (r_i <= i_leff)) begin
      r_i <= r_i + W'(1);
      if (r_i <= i_aeff) begin
        r_sn <= r_sn + W'(1);
      end
    end
  end

  assign o_i  = r_i;
  assign o_sn = r_sn;

endmodule

// File: rtl/sum_run_sched.sv
// Two-requester round-robin scheduler driving the bounded-sum datapath,
// with a sticky checker on the invariant sn == min(i-1, Aeff).
//
// state | meaning
// IDLE  | sample requests, pick a grant
// LOAD  | reset datapath, latch clamped limits of the granted requester
// RUN   | step datapath until i passes Leff
// DONE  | one-cycle ack to the granted requester, result valid
module sum_run_sched
  import sum_sched_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int TOTAL_MAX = DEF_TOTAL_MAX,
  parameter int ACC_MAX   = DEF_ACC_MAX
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [1:0]   i_req,
  input  logic [W-1:0] i_lim0,
  input  logic [W-1:0] i_lim1,
  input  logic [W-1:0] i_acc0,
  input  logic [W-1:0] i_acc1,
  output logic [1:0]   o_ack,
  output logic [W-1:0] o_result,
  output logic         o_busy,
  output logic         o_gnt_id,
  output logic [W-1:0] o_i,
  output logic [W-1:0] o_sn,
  output logic         o_err
);

  localparam logic [W-1:0] L_TMAX = W'(TOTAL_MAX);
  localparam logic [W-1:0] L_AMAX = W'(ACC_MAX);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_ptr;
  logic         r_gnt;
  logic         w_gnt_nxt;
  logic [W-1:0] r_leff;
  logic [W-1:0] r_aeff;
  logic [W-1:0] r_result;
  logic         r_err;

  logic [W-1:0] w_i;
  logic [W-1:0] w_sn;
  logic [W-1:0] w_lim;
  logic [W-1:0] w_acc;
  logic [W-1:0] w_leff;
  logic [W-1:0] w_aeff;
  logic [W-1:0] w_sn_exp;
  logic         w_load;
  logic         w_en;
  logic         w_run_end;

  assign w_lim     = r_gnt ? i_lim1 : i_lim0;
  assign w_acc     = r_gnt ? i_acc1 : i_acc0;
  assign w_leff    = min_w(w_lim, L_TMAX);
  assign w_aeff    = min_w(min_w(w_acc, L_AMAX), w_leff);
  assign w_load    = (r_state == ST_LOAD);
  assign w_en      = (r_state == ST_RUN);
  assign w_run_end = w_en && (w_i > r_leff);
  assign w_sn_exp  = min_w(w_i - W'(1), r_aeff);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      ST_IDLE: begin
        if (i_req != 2'b00) begin
          w_state_nxt = ST_LOAD;
          // On contention the pointer names the requester not served last.
          w_gnt_nxt   = (&i_req) ? r_ptr : i_req[1];
        end
      end
      ST_LOAD: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_i > r_leff) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 1'b0;
      r_ptr    <= 1'b0;
      r_leff   <= '0;
      r_aeff   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      if (w_load) begin
        r_leff <= w_leff;
        r_aeff <= w_aeff;
      end
      // sn is frozen once i passes Leff, so capturing on RUN exit is the final sum.
      if (w_run_end) begin
        r_result <= w_sn;
      end
      if (r_state == ST_DONE) begin
        r_ptr <= ~r_gnt;
      end
      if (w_en && (w_sn != w_sn_exp)) begin
        r_err <= 1'b1;
      end
    end
  end

  sum_datapath #(.W(W)) u_dp (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_en    (w_en),
    .i_leff  (r_leff),
    .i_aeff  (r_aeff),
    .o_i     (w_i),
    .o_sn    (w_sn)
  );

  assign o_ack    = (r_state == ST_DONE) ? {r_gnt, ~r_gnt} : 2'b00;
  assign o_busy   = (r_state != ST_IDLE);
  assign o_gnt_id = r_gnt;
  assign o_result = r_result;
  assign o_i      = w_i;
  assign o_sn     = w_sn;
  assign o_err    = r_err;

endmodule

// File: tb/tb_sum_run_sched.sv
// Scoreboard bench for sum_run_sched: directed runs push expected acks,
// an independent monitor pops and compares whenever the DUT acks.
module tb_sum_run_sched;

  localparam int W = 11;

  logic         i_clk;
  logic         i_rst_n;
  logic [1:0]   i_req;
  logic [W-1:0] i_lim0, i_lim1, i_acc0, i_acc1;
  logic [1:0]   o_ack;
  logic [W-1:0] o_result;
  logic         o_busy;
  logic         o_gnt_id;
  logic [W-1:0] o_i;
  logic [W-1:0] o_sn;
  logic         o_err;

  sum_run_sched dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (i_req),
    .i_lim0   (i_lim0),
    .i_lim1   (i_lim1),
    .i_acc0   (i_acc0),
    .i_acc1   (i_acc1),
    .o_ack    (o_ack),
    .o_result (o_result),
    .o_busy   (o_busy),
    .o_gnt_id (o_gnt_id),
    .o_i      (o_i),
    .o_sn     (o_sn),
    .o_err    (o_err)
  );

  typedef struct {
    logic [1:0]   ack;
    logic [W-1:0] res;
    logic         chk_res;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: compares every ack against the scoreboard and drops the served request.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && (o_ack != 2'b00)) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {30'd0, o_ack}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_onehot", {30'd0, o_ack}, {30'd0, e.ack});
          if (e.chk_res) chk("ack_result", {21'd0, o_result}, {21'd0, e.res});
          chk("ack_cycle", cyc, e.cyc);
        end
        i_req = i_req & ~o_ack;
      end
    end
  end

  task automatic push(input logic [1:0] ack, input int res, input logic chk_res, input int cyc_at);
    exp_t e;
    e.ack     = ack;
    e.res     = W'(res);
    e.chk_res = chk_res;
    e.cyc     = cyc_at;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("wait_done_timeout", n, 0);
      sb.delete();
    end
    @(negedge i_clk);
  endtask

  task automatic wait_i(input int val, input int budget);
    int n;
    n = 0;
    while (!(o_busy && o_i == W'(val)) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (!(o_busy && o_i == W'(val))) chk("wait_i_timeout", {21'd0, o_i}, val);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_req   = 2'b00;
    sb.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic run0(input int lim, input int acc, input int res, input int lat);
    i_lim0 = W'(lim);
    i_acc0 = W'(acc);
    push(2'b01, res, 1'b1, cyc + lat);
    i_req[0] = 1'b1;
    wait_done(lat + 20);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_req   = 2'b00;
    i_lim0  = '0; i_lim1 = '0; i_acc0 = '0; i_acc1 = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_ack",    {30'd0, o_ack}, 0);
    chk("rst_result", {21'd0, o_result}, 0);
    chk("rst_busy",   {31'd0, o_busy}, 0);
    chk("rst_gnt",    {31'd0, o_gnt_id}, 0);
    chk("rst_i",      {21'd0, o_i}, 1);
    chk("rst_sn",     {21'd0, o_sn}, 0);
    chk("rst_err",    {31'd0, o_err}, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Full-length run at both clamps.
    run0(250, 150, 150, 253);
    chk("run_max_err", {31'd0, o_err}, 0);
    chk("run_max_gnt", {31'd0, o_gnt_id}, 0);

    // Contention from reset: requester 0 first, requester 1 gets A clamped to L.
    do_reset();
    i_lim0 = 11'd5; i_acc0 = 11'd3; i_lim1 = 11'd4; i_acc1 = 11'd9;
    push(2'b01, 3, 1'b1, cyc + 8);
    push(2'b10, 4, 1'b1, cyc + 16);
    i_req = 2'b11;
    wait_done(40);
    chk("rr_gnt_last", {31'd0, o_gnt_id}, 1);

    // Zero-length run on requester 1.
    i_lim1 = 11'd0; i_acc1 = 11'd7;
    push(2'b10, 0, 1'b1, cyc + 3);
    i_req = 2'b10;
    wait_done(20);
    chk("zero_i", {21'd0, o_i}, 1);
    chk("zero_sn", {21'd0, o_sn}, 0);

    // Clamping of oversize limits, and an accumulate limit above L.
    run0(1000, 1000, 150, 253);
    run0(300, 400, 150, 253);
    run0(7, 200, 7, 10);
    run0(10, 4, 4, 13);

    // Last served was 0, so contention now favours requester 1.
    i_lim0 = 11'd2; i_acc0 = 11'd2; i_lim1 = 11'd3; i_acc1 = 11'd1;
    push(2'b10, 1, 1'b1, cyc + 6);
    push(2'b01, 2, 1'b1, cyc + 12);
    i_req = 2'b11;
    wait_done(40);

    // Reset in the middle of a run.
    i_lim0 = 11'd100; i_acc0 = 11'd60;
    push(2'b01, 60, 1'b1, cyc + 103);
    i_req = 2'b01;
    wait_i(40, 100);
    i_rst_n = 1'b0;
    i_req   = 2'b00;
    sb.delete();
    #1;
    chk("abort_ack",    {30'd0, o_ack}, 0);
    chk("abort_busy",   {31'd0, o_busy}, 0);
    chk("abort_i",      {21'd0, o_i}, 1);
    chk("abort_sn",     {21'd0, o_sn}, 0);
    chk("abort_result", {21'd0, o_result}, 0);
    repeat (2) @(negedge i_clk);
    chk("abort_no_ack", {30'd0, o_ack}, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    run0(6, 2, 2, 9);

    // Corrupt sn mid-run: err must rise on the next cycle and stay sticky.
    i_lim0 = 11'd20; i_acc0 = 11'd10;
    push(2'b01, 0, 1'b0, cyc + 23);
    i_req = 2'b01;
    wait_i(5, 20);
    chk("err_before_force", {31'd0, o_err}, 0);
    force dut.u_dp.r_sn = 11'd77;
    @(negedge i_clk);
    release dut.u_dp.r_sn;
    chk("err_after_force", {31'd0, o_err}, 1);
    wait_done(40);
    run0(3, 2, 2, 6);
    chk("err_sticky", {31'd0, o_err}, 1);
    do_reset();
    chk("err_cleared", {31'd0, o_err}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sum_run_sched.md
# sum_run_sched

Scheduler for the bounded sum datapath: two requesters each ask for a counting run with their own total and accumulate limits. A round-robin arbiter grants one run at a time. A four-state FSM loads the datapath, steps it to completion and returns the final sum with a one-cycle ack. A built-in checker tracks the datapath invariant `sn == min(i-1, acc)` and flags any violation with a sticky error.

## Interface
- `W`, 11, datapath width for `i`, `sn`, limits.
- `TOTAL_MAX`, 250, clamp for total limit; must be ≤ 2^W−2.
- `ACC_MAX`, 150, clamp for accumulate limit.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-requester run request; level, held until ack.
- `lim0`, `lim1`  in  W  total limit L per requester.
- `acc0`, `acc1`  in  W  accumulate limit A per requester.
- `ack`  out  2  one-hot, one-cycle pulse to the served requester.
- `result`  out  W  final `sn`; valid while `ack` ≠ 0, held until the next DONE.
- `busy`  out  1  high in LOAD, RUN, DONE.
- `gnt_id`  out  1  index of the current or last granted requester.
- `i`, `sn`  out  W  live datapath registers.
- `err`  out  1  sticky invariant violation flag.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: `req` is sampled only in this state.
  - If `req` ≠ 0, grant and go to LOAD.
  - If both requests are high, grant the requester not last served. The round-robin pointer resets to favour requester 0.
  - If `req` = 0, stay in IDLE.
- LOAD:
  - Set `i` ← 1 and `sn` ← 0.
  - Latch `Leff` = min(`lim[g]`, TOTAL_MAX).
  - Latch `Aeff` = min(`acc[g]`, ACC_MAX, `Leff`).
- RUN, each cycle:
  - If `i` ≤ `Leff`: `i` ← `i`+1, and also `sn` ← `sn`+1 when `i` ≤ `Aeff`.
  - Else go to DONE; `i` and `sn` hold.
- DONE:
  - Drive `ack[g]` = 1 and capture `result` = `sn`.
  - Move the round-robin pointer to the other requester and go to IDLE.
- Final sum = min(`Leff`, `Aeff`).
- With `Leff` = 0: RUN lasts one cycle and `result` = 0.
- Outside RUN, `i` and `sn` hold their last values.
- Requester handshake: `req[g]` must be low by the clock edge that ends the DONE cycle. A request held high past that edge is a new request.
- Limits change freely; they are sampled only in LOAD.
- Checker, active in RUN: if `sn` ≠ min(`i`−1, `Aeff`), set `err` = 1. `err` clears only on reset.
- Arithmetic is unsigned W-bit. No wrap is possible given the TOTAL_MAX bound.

## Timing
- Reset values: state IDLE, `i` = 1, `sn` = 0, `ack` = 0, `result` = 0, `busy` = 0, `gnt_id` = 0, `err` = 0, pointer = 0.
- Reset asserted mid-run aborts the run immediately; no ack is issued.
- If `req` is seen in IDLE at cycle 0:
  - LOAD at cycle 1.
  - RUN at cycles 2 .. L+2.
  - DONE (`ack` high) at cycle L+3.
  - Back in IDLE at cycle L+4.
- Back-to-back: a pending second request is granted in the IDLE cycle after DONE. Turnaround overhead is 3 cycles per run.
- `ack`, `busy` and `gnt_id` are decoded from registered state only; no input-to-output combinational path.

## Structure
- Package `sum_sched_pkg`: state enum, default `W`/`TOTAL_MAX`/`ACC_MAX` constants, and a `min` function.
- Sub-module `sum_datapath`: the `i`/`sn` registers with `load`, `en`, `Leff`, `Aeff` inputs.
- Top level holds the FSM, arbiter, limit latches, result register and checker.

## Test plan
- Reset, `req` = 01, `lim0` = 250, `acc0` = 150 → `ack` = 01 at cycle 253, `result` = 150, `err` = 0.
- `req` = 11 from reset, `lim0` = 5, `acc0` = 3, `lim1` = 4, `acc1` = 9 → req0 is served first with `result` 3 and `ack` at cycle 8. Then req1 with `result` 4 (A clamped to L), `ack` at cycle 16.
- `lim1` = 0, `req` = 10 → `ack` = 10 three cycles after sampling, `result` = 0, `i` stays 1.
- `lim0` = 1000 → clamped to 250; `lim0` = 300, `acc0` = 400 → `result` = 150.
- `rst` pulsed low during RUN at `i` = 40 → all outputs return to reset values at once, no `ack`. Next `req` runs cleanly.
- Force `sn` via bench during RUN → `err` rises next cycle and stays high through later runs until reset.
